// File: rtl/token_rr_dispatcher_if.sv
// ---------------------------------------------------------------------------
// token_rr_dispatcher_if
// Bundles the token stream, the per-lane request/grant lines and the weight
// configuration handshake of the weighted round-robin token dispatcher.
//
// Signals
//   a           serial token input, 1 = one token this cycle
//   req         per-lane enable, lane may receive tokens while high
//   b           one-hot token output, same cycle as a
//   drop        token arrived while no lane was enabled
//   cfg_valid   weight write request
//   cfg_ready   weight write can be accepted this cycle
//   cfg_ch      lane index to configure
//   cfg_weight  new weight for cfg_ch
//   owner       current round-robin pointer (registered)
//
// Modports
//   master  the token source / configuring agent
//   slave   the dispatcher itself
// ---------------------------------------------------------------------------
interface token_rr_dispatcher_if #(
   parameter int N_OUT = 4,
   parameter int W_W   = 4
);

   localparam int CH_W = $clog2(N_OUT);

   logic             a;
   logic [N_OUT-1:0] req;
   logic [N_OUT-1:0] b;
   logic             drop;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [W_W-1:0]   cfg_weight;
   logic [CH_W-1:0]  owner;

   modport master (
      output a, req, cfg_valid, cfg_ch, cfg_weight,
      input  b, drop, cfg_ready, owner
   );

   modport slave (
      input  a, req, cfg_valid, cfg_ch, cfg_weight,
      output b, drop, cfg_ready, owner
   );

endinterface

// File: rtl/token_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// token_rr_dispatcher
// Weighted round-robin scheduler sharing one serial token stream among N_OUT
// requesters. Every token goes to exactly one enabled lane; the owning lane
// keeps ownership for its weight's worth of consecutive tokens and then
// ownership rotates to the next lane. Lanes with req low are skipped, and a
// lane that drops req mid-turn forfeits the rest of its turn.
//
// Parameters
//   N_OUT  number of lanes (>= 2)
//   W_W    weight width, weight 0 behaves like weight 1
//
// Ports
//   clk    clock
//   rst    synchronous active-high reset
//   link   token_rr_dispatcher_if.slave (a, req, b, drop, cfg_*, owner)
// ---------------------------------------------------------------------------
module token_rr_dispatcher #(
   parameter int N_OUT = 4,
   parameter int W_W   = 4
) (
   input logic                  clk,
   input logic                  rst,
   token_rr_dispatcher_if.slave link
);

   localparam int CH_W = $clog2(N_OUT);

   // Round-robin pointer, tokens already given to ptr this turn, lane weights
   logic [CH_W-1:0] ptr;
   logic [W_W-1:0]  cnt;
   logic [W_W-1:0]  weight [N_OUT];

   logic [CH_W-1:0] grant;
   logic [CH_W-1:0] next_ptr;
   logic [W_W-1:0]  next_cnt;
   logic [W_W-1:0]  used;
   logic [W_W-1:0]  weff;
   logic            any_req;
   logic            token;
   logic            cfg_in_range;
   logic            cfg_accept;

   assign any_req = |link.req;
   assign token   = !rst && link.a && any_req;

   // Grant selection: the current owner keeps the token while it still
   // requests; otherwise the first requesting lane found walking forward
   // from the owner (wrapping round) takes it. When no lane requests the
   // result is irrelevant because nothing is granted.
   always_comb begin
      int              idx;
      logic [CH_W-1:0] idx_sel;
      logic            found;
      grant   = ptr;
      found   = 1'b0;
      idx     = 0;
      idx_sel = '0;
      for (int k = 0; k < N_OUT; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_OUT) begin
            idx = idx - N_OUT;
         end
         idx_sel = CH_W'(idx);
         if (!found && link.req[idx_sel]) begin
            grant = idx_sel;
            found = 1'b1;
         end
      end
   end

   // Turn bookkeeping for a granted token. A token to a lane other than
   // the pointer starts a fresh turn for that lane. When the lane reaches
   // its effective weight the turn ends and the pointer moves past it;
   // otherwise the lane becomes (or stays) the owner with the new count.
   always_comb begin
      weff     = (weight[grant] == '0) ? W_W'(1) : weight[grant];
      used     = (grant == ptr) ? cnt + W_W'(1) : W_W'(1);
      next_ptr = grant;
      next_cnt = used;
      if (used == weff) begin
         next_ptr = (int'(grant) == N_OUT - 1) ? '0 : grant + CH_W'(1);
         next_cnt = '0;
      end
   end

   // Token output: one-hot grant while a token is present and some lane
   // requests; everything is held low during reset.
   always_comb begin
      link.b = '0;
      if (token) begin
         link.b[grant] = 1'b1;
      end
   end

   assign link.drop  = !rst && link.a && !any_req;
   assign link.owner = ptr;

   // A lane's weight may not change while that lane is part-way through a
   // turn, so the write waits until the turn has finished. Indices beyond
   // the last lane are accepted and simply discarded.
   assign link.cfg_ready = !rst && !((link.cfg_ch == ptr) && (cnt != '0));
   assign cfg_in_range   = int'(link.cfg_ch) < N_OUT;
   assign cfg_accept     = link.cfg_valid && link.cfg_ready && cfg_in_range;

   // State update. The token in the same cycle as an accepted weight write
   // is scheduled with the old weight; the new weight counts from the next
   // cycle because both are registered at the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < N_OUT; i++) begin
            weight[i] <= W_W'(1);
         end
      end else begin
         if (token) begin
            ptr <= next_ptr;
            cnt <= next_cnt;
         end
         if (cfg_accept) begin
            weight[link.cfg_ch] <= link.cfg_weight;
         end
      end
   end

   // At most one lane ever receives a given token, and a token is never
   // both granted and dropped.
   a_onehot_b : assert property (@(posedge clk) $onehot0(link.b));
   a_b_drop_exclusive : assert property (@(posedge clk) !((|link.b) && link.drop));

endmodule

// File: tb/tb_token_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_token_rr_dispatcher
// Scoreboard bench for token_rr_dispatcher (N_OUT=4, W_W=4). The driver
// computes the expected outputs of each cycle from a reference model of the
// scheduling rules and queues them; an independent monitor pops and compares
// them against the DUT. Directed sequences additionally compare the logged
// list of granted lanes against hand-written constants.
// ---------------------------------------------------------------------------
module tb_token_rr_dispatcher;

   localparam int N   = 4;
   localparam int W_W = 4;

   typedef struct {
      logic [N-1:0] b;
      logic         drop;
      logic         cfg_ready;
      logic [1:0]   owner;
      int           cycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   token_rr_dispatcher_if #(.N_OUT(N), .W_W(W_W)) link ();

   token_rr_dispatcher #(.N_OUT(N), .W_W(W_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   dut_lanes[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cycle   = 0;

   // Reference model: who owns the turn, how many tokens it has used, weights
   int  m_owner = 0;
   int  m_used  = 0;
   int  m_w[N];
   bit  m_known = 0;

   // Pending weight write held by the configuring agent until accepted
   bit         cfg_pend = 0;
   logic [1:0] cfg_ch_p = '0;
   logic [3:0] cfg_w_p  = '0;

   // Single comparison with bookkeeping
   task automatic checkOutput(input string name, input int cyc,
                              input logic [31:0] act, input logic [31:0] req_v);
      n_tests++;
      if (act !== req_v) begin
         n_fail++;
         $display("[TB] FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, req_v);
      end
   endtask

   // Compare the logged grant lanes of a directed sequence with a fixed list
   task automatic checkLanes(input string name, input int exp_l[$]);
      string got_s;
      string exp_s;
      bit    ok;
      got_s = "";
      exp_s = "";
      ok    = (dut_lanes.size() == exp_l.size());
      foreach (dut_lanes[i]) got_s = $sformatf("%s%0d ", got_s, dut_lanes[i]);
      foreach (exp_l[i]) begin
         exp_s = $sformatf("%s%0d ", exp_s, exp_l[i]);
         if (ok && dut_lanes[i] != exp_l[i]) ok = 0;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL %s lanes: got [ %s], required [ %s]", name, got_s, exp_s);
      end
   endtask

   // Drive one cycle at the falling edge, queue its expected outputs and
   // advance the model to the state after the following rising edge.
   task automatic applyStimulus(input logic a_in, input logic [N-1:0] req_in, input logic rst_in);
      exp_t e;
      int   g;
      int   used;
      int   weff;
      @(negedge clk);
      cycle++;
      rst             = rst_in;
      link.a          = a_in;
      link.req        = req_in;
      link.cfg_valid  = cfg_pend;
      link.cfg_ch     = cfg_ch_p;
      link.cfg_weight = cfg_w_p;
      e.cycle = cycle;
      e.owner = 2'(m_owner);
      if (rst_in) begin
         e.b         = '0;
         e.drop      = 1'b0;
         e.cfg_ready = 1'b0;
         if (m_known) exp_q.push_back(e);
         m_owner = 0;
         m_used  = 0;
         foreach (m_w[i]) m_w[i] = 1;
         m_known = 1;
      end else begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_in[(m_owner + k) % N]) g = (m_owner + k) % N;
         end
         e.b         = (a_in && g >= 0) ? N'(1 << g) : '0;
         e.drop      = a_in && (g < 0);
         e.cfg_ready = !(int'(cfg_ch_p) == m_owner && m_used != 0);
         exp_q.push_back(e);
         if (a_in && g >= 0) begin
            used = (g == m_owner) ? m_used + 1 : 1;
            weff = (m_w[g] == 0) ? 1 : m_w[g];
            if (used == weff) begin
               m_owner = (g + 1) % N;
               m_used  = 0;
            end else begin
               m_owner = g;
               m_used  = used;
            end
         end
         if (cfg_pend && e.cfg_ready) begin
            m_w[cfg_ch_p] = int'(cfg_w_p);
            cfg_pend = 0;
         end
      end
   endtask

   // Issue a weight write with no tokens flowing, bounded wait for acceptance
   task automatic doCfg(input logic [1:0] ch, input logic [3:0] w);
      cfg_pend = 1;
      cfg_ch_p = ch;
      cfg_w_p  = w;
      for (int i = 0; i < 20 && cfg_pend; i++) applyStimulus(1'b0, '0, 1'b0);
      n_tests++;
      if (cfg_pend) begin
         n_fail++;
         $display("[TB] FAIL cfg_accept_timeout: got pending, required accepted");
         cfg_pend = 0;
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, 1'b1);
      #3;
      dut_lanes.delete();
   endtask

   // Monitor: compare each queued expectation in the middle of its cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("b", e.cycle, 32'(link.b), 32'(e.b));
            checkOutput("drop", e.cycle, 32'(link.drop), 32'(e.drop));
            checkOutput("cfg_ready", e.cycle, 32'(link.cfg_ready), 32'(e.cfg_ready));
            checkOutput("owner", e.cycle, 32'(link.owner), 32'(e.owner));
            for (int i = 0; i < N; i++) begin
               if (link.b[i] === 1'b1) dut_lanes.push_back(i);
            end
         end
      end
   end

   // Directed sequences followed by randomized traffic
   initial begin
      int         exp_l[$];
      logic [7:0] pat;
      logic [N-1:0] r_req;
      rst             = 1'b1;
      link.a          = 1'b0;
      link.req        = '0;
      link.cfg_valid  = 1'b0;
      link.cfg_ch     = '0;
      link.cfg_weight = '0;
      foreach (m_w[i]) m_w[i] = 1;

      // Two lanes, weight 1: halve-tokens pattern
      doReset();
      pat = 8'b1101_0111;
      for (int i = 7; i >= 0; i--) applyStimulus(pat[i], 4'b0011, 1'b0);
      #3;
      exp_l = '{0, 1, 0, 1, 0, 1};
      checkLanes("halve", exp_l);

      // Weights {1,2,3,1}
      doReset();
      doCfg(2'd1, 4'd2);
      doCfg(2'd2, 4'd3);
      dut_lanes.delete();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b1111, 1'b0);
      #3;
      exp_l = '{0, 1, 1, 2, 2, 2, 3, 0};
      checkLanes("weighted", exp_l);

      // Skipping idle lanes, then a dropped token
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0101, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0);
      #3;
      exp_l = '{0, 2, 0, 2};
      checkLanes("skip", exp_l);

      // Weight write to a lane mid-turn waits for the turn to end
      doReset();
      doCfg(2'd0, 4'd3);
      dut_lanes.delete();
      applyStimulus(1'b1, 4'b0011, 1'b0);
      cfg_pend = 1;
      cfg_ch_p = 2'd0;
      cfg_w_p  = 4'd1;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0011, 1'b0);
      #3;
      exp_l = '{0, 0, 0, 1, 0, 1};
      checkLanes("midturn_cfg", exp_l);

      // Weight 0 behaves as weight 1
      doReset();
      doCfg(2'd1, 4'd0);
      dut_lanes.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0011, 1'b0);
      #3;
      exp_l = '{0, 1, 0, 1};
      checkLanes("weight0", exp_l);

      // Reset in the middle of a turn
      doReset();
      doCfg(2'd0, 4'd3);
      dut_lanes.delete();
      applyStimulus(1'b1, 4'b0011, 1'b0);
      applyStimulus(1'b1, 4'b0011, 1'b1);
      applyStimulus(1'b1, 4'b0011, 1'b1);
      applyStimulus(1'b1, 4'b0011, 1'b0);
      applyStimulus(1'b1, 4'b0011, 1'b0);
      #3;
      exp_l = '{0, 0, 1};
      checkLanes("reset_midturn", exp_l);

      // Randomized traffic against the model
      r_req = 4'b1111;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r_req = N'($urandom_range(0, 15));
         if (!cfg_pend && $urandom_range(0, 7) == 0) begin
            cfg_pend = 1;
            cfg_ch_p = 2'($urandom_range(0, 3));
            cfg_w_p  = 4'($urandom_range(0, 15));
         end
         applyStimulus($urandom_range(0, 3) != 0, r_req, $urandom_range(0, 99) == 0);
      end

      @(negedge clk);
      #3;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
